// File: rtl/stage_fifo_deep.sv
// stage_fifo_deep: Depth-entry, Width-bit FIFO with a 0/1/2-per-cycle
// valid/ready protocol on both ports, occupancy/full/empty status and an
// optional same-cycle write-to-read bypass (FallThrough).
module stage_fifo_deep #(
    parameter int unsigned Width       = 32,
    parameter int unsigned Depth       = 4,
    parameter bit          FallThrough = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [1:0]                   wr_valid_i,
    input  logic [Width-1:0]             wr_data0_i,
    input  logic [Width-1:0]             wr_data1_i,
    output logic [1:0]                   wr_rdy_o,
    input  logic [1:0]                   rd_rdy_i,
    output logic [1:0]                   rd_valid_o,
    output logic [Width-1:0]             rd_data0_o,
    output logic [Width-1:0]             rd_data1_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned LW = $clog2(Depth + 1);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = LW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;

    logic [1:0]       w_rq;
    logic [1:0]       w_wq;
    logic [1:0]       w_ns;
    logic [1:0]       w_nw;
    logic [1:0]       w_nr;
    logic [1:0]       w_avail;
    logic [CW-1:0]    w_lvl;
    logic [CW-1:0]    w_room;
    logic [CW-1:0]    w_fill;
    logic [PW-1:0]    w_rd_ptr1;
    logic [PW-1:0]    w_wr_ptr1;

    // Modulo-Depth increment by compare-and-wrap, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake arithmetic; room counts stored reads only, so the write side
    // never depends on bypassed items and no combinational loop forms.
    always_comb begin
        w_rq      = (rd_rdy_i == 2'b11) ? 2'd2 : (rd_rdy_i == 2'b01) ? 2'd1 : 2'd0;
        w_wq      = (wr_valid_i == 2'b11) ? 2'd2 : (wr_valid_i == 2'b01) ? 2'd1 : 2'd0;
        w_lvl     = CW'(r_level);
        w_ns      = (w_lvl < CW'(w_rq)) ? w_lvl[1:0] : w_rq;
        w_room    = CW'(Depth) - w_lvl + CW'(w_ns);
        w_nw      = (w_room < CW'(w_wq)) ? w_room[1:0] : w_wq;
        w_fill    = FallThrough ? (w_lvl + CW'(w_nw)) : w_lvl;
        w_avail   = (w_fill >= CW'(2)) ? 2'd2 : w_fill[1:0];
        w_nr      = (w_avail < w_rq) ? w_avail : w_rq;
        w_rd_ptr1 = ptr_inc(r_rd_ptr);
        w_wr_ptr1 = ptr_inc(r_wr_ptr);

        if (w_room >= CW'(2)) begin
            wr_rdy_o = 2'b11;
        end else if (w_room == CW'(1)) begin
            wr_rdy_o = 2'b01;
        end else begin
            wr_rdy_o = 2'b00;
        end

        rd_valid_o = (w_avail == 2'd2) ? 2'b11 : (w_avail == 2'd1) ? 2'b01 : 2'b00;
    end

    // Read data: stored entries, or write-port data bypassed when under two entries.
    always_comb begin
        rd_data0_o = r_mem[r_rd_ptr];
        rd_data1_o = r_mem[w_rd_ptr1];
        if (FallThrough) begin
            if (r_level == '0) begin
                rd_data0_o = wr_data0_i;
                rd_data1_o = wr_data1_i;
            end else if (r_level == LW'(1)) begin
                rd_data1_o = wr_data0_i;
            end
        end
    end

    // State update: reset clears everything, flush empties but keeps memory.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_nw != 2'd0) begin
                r_mem[r_wr_ptr] <= wr_data0_i;
            end
            if (w_nw == 2'd2) begin
                r_mem[w_wr_ptr1] <= wr_data1_i;
            end
            r_wr_ptr <= (w_nw == 2'd2) ? ptr_inc(w_wr_ptr1) :
                        (w_nw == 2'd1) ? w_wr_ptr1 : r_wr_ptr;
            r_rd_ptr <= (w_nr == 2'd2) ? ptr_inc(w_rd_ptr1) :
                        (w_nr == 2'd1) ? w_rd_ptr1 : r_rd_ptr;
            r_level  <= r_level + LW'(w_nw) - LW'(w_nr);
        end
    end

    // Status flags come straight from the occupancy register.
    always_comb begin
        level_o = r_level;
        empty_o = (r_level == '0);
        full_o  = (r_level == LW'(Depth));
    end

endmodule

// File: tb/tb_stage_fifo_deep.sv
// Bench for stage_fifo_deep: one Depth=3 non-bypass instance and one Depth=4
// fall-through instance. Stimulus pushes expected read data into per-instance
// queues; monitors pop and compare on every accepted read.
module tb_stage_fifo_deep;

    logic clk;
    int   checks;
    int   errors;

    // Instance A: Depth 3, FallThrough 0
    logic        a_rst, a_flush;
    logic [1:0]  a_wv, a_rr, a_wrdy, a_rdv;
    logic [31:0] a_d0, a_d1, a_q0, a_q1;
    logic [1:0]  a_lvl;
    logic        a_empty, a_full;

    // Instance B: Depth 4, FallThrough 1
    logic        b_rst, b_flush;
    logic [1:0]  b_wv, b_rr, b_wrdy, b_rdv;
    logic [31:0] b_d0, b_d1, b_q0, b_q1;
    logic [2:0]  b_lvl;
    logic        b_empty, b_full;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    stage_fifo_deep #(.Width(32), .Depth(3), .FallThrough(1'b0)) u_a (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
        .wr_valid_i(a_wv), .wr_data0_i(a_d0), .wr_data1_i(a_d1), .wr_rdy_o(a_wrdy),
        .rd_rdy_i(a_rr), .rd_valid_o(a_rdv), .rd_data0_o(a_q0), .rd_data1_o(a_q1),
        .level_o(a_lvl), .empty_o(a_empty), .full_o(a_full)
    );

    stage_fifo_deep #(.Width(32), .Depth(4), .FallThrough(1'b1)) u_b (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
        .wr_valid_i(b_wv), .wr_data0_i(b_d0), .wr_data1_i(b_d1), .wr_rdy_o(b_wrdy),
        .rd_rdy_i(b_rr), .rd_valid_o(b_rdv), .rd_data0_o(b_q0), .rd_data1_o(b_q1),
        .level_o(b_lvl), .empty_o(b_empty), .full_o(b_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] act, input bit use_b);
        logic [31:0] e;
        if (use_b ? (qb.size() == 0) : (qa.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s got %0h expected <nothing queued>", nm, act);
        end else begin
            e = use_b ? qb.pop_front() : qa.pop_front();
            chk(nm, act, e);
        end
    endtask

    // Monitor A: compare every read that will commit at the next edge
    always @(negedge clk) begin
        if (!a_rst && !a_flush) begin
            if (a_rdv[0] && a_rr[0]) pop_chk("a_rd0", a_q0, 1'b0);
            if (a_rdv[1] && a_rr[1]) pop_chk("a_rd1", a_q1, 1'b0);
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!b_rst && !b_flush) begin
            if (b_rdv[0] && b_rr[0]) pop_chk("b_rd0", b_q0, 1'b1);
            if (b_rdv[1] && b_rr[1]) pop_chk("b_rd1", b_q1, 1'b1);
        end
    end

    task automatic set_a(input logic [1:0] wv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] rr);
        a_wv = wv; a_d0 = d0; a_d1 = d1; a_rr = rr;
    endtask

    task automatic set_b(input logic [1:0] wv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] rr);
        b_wv = wv; b_d0 = d0; b_d1 = d1; b_rr = rr;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; checks = 0; errors = 0;
        a_rst = 1; a_flush = 0; set_a(2'b00, 0, 0, 2'b00);
        b_rst = 1; b_flush = 0; set_b(2'b00, 32'h1234, 32'h5678, 2'b00);
        repeat (2) nxt();

        // Reset values
        @(negedge clk);
        chk("a_rst_rdv", a_rdv, 2'b00);
        chk("a_rst_wrdy", a_wrdy, 2'b11);
        chk("a_rst_lvl", a_lvl, 0);
        chk("a_rst_empty", a_empty, 1);
        chk("a_rst_full", a_full, 0);
        chk("a_rst_q0", a_q0, 0);
        chk("b_rst_q0_follow", b_q0, 32'h1234);
        chk("b_rst_q1_follow", b_q1, 32'h5678);
        nxt();
        a_rst = 0; b_rst = 0;
        set_b(2'b00, 0, 0, 2'b00);

        // Fill/drain on A
        set_a(2'b11, 32'hA, 32'hB, 2'b00); qa.push_back(32'hA); qa.push_back(32'hB);
        @(negedge clk); chk("fill_wrdy0", a_wrdy, 2'b11); nxt();
        set_a(2'b01, 32'hC, 0, 2'b00); qa.push_back(32'hC);
        @(negedge clk); chk("fill_wrdy1", a_wrdy, 2'b01); chk("fill_lvl2", a_lvl, 2); nxt();
        set_a(2'b00, 0, 0, 2'b00);
        @(negedge clk);
        chk("full_lvl", a_lvl, 3); chk("full_flag", a_full, 1);
        chk("full_wrdy", a_wrdy, 2'b00); chk("full_rdv", a_rdv, 2'b11);
        nxt();
        set_a(2'b00, 0, 0, 2'b11);
        @(negedge clk); chk("drain_wrdy", a_wrdy, 2'b11); nxt();
        set_a(2'b00, 0, 0, 2'b01);
        @(negedge clk); chk("drain_lvl1", a_lvl, 1); chk("drain_rdv", a_rdv, 2'b01); nxt();
        set_a(2'b00, 0, 0, 2'b00);
        @(negedge clk); chk("drain_lvl0", a_lvl, 0); chk("drain_empty", a_empty, 1); nxt();

        // Wrap: 0..19 through Depth 3 in pairs
        for (int i = 0; i < 10; i++) begin
            set_a(2'b11, 32'(2 * i), 32'(2 * i + 1), 2'b11);
            qa.push_back(32'(2 * i)); qa.push_back(32'(2 * i + 1));
            @(negedge clk);
            if (i == 0) chk("wrap_empty_rdv", a_rdv, 2'b00);
            else begin
                chk("wrap_lvl", a_lvl, 2);
                chk("wrap_wrdy", a_wrdy, 2'b11);
            end
            nxt();
        end
        set_a(2'b00, 0, 0, 2'b11);
        nxt();
        set_a(2'b00, 0, 0, 2'b00);
        @(negedge clk); chk("wrap_end_lvl", a_lvl, 0); nxt();

        // Partial acceptance at L = Depth-1
        set_a(2'b11, 32'hD0, 32'hD1, 2'b00); qa.push_back(32'hD0); qa.push_back(32'hD1);
        nxt();
        set_a(2'b11, 32'hE0, 32'hE1, 2'b00); qa.push_back(32'hE0);
        @(negedge clk); chk("part_wrdy", a_wrdy, 2'b01); nxt();
        // Full with single read and dual write offer
        set_a(2'b11, 32'hF0, 32'hF1, 2'b01); qa.push_back(32'hF0);
        @(negedge clk);
        chk("part_full", a_full, 1);
        chk("fullrd_wrdy", a_wrdy, 2'b01);
        nxt();
        set_a(2'b00, 0, 0, 2'b11);
        @(negedge clk); chk("fullrd_lvl", a_lvl, 3); nxt();
        set_a(2'b00, 0, 0, 2'b11);
        @(negedge clk); chk("fullrd_last_rdv", a_rdv, 2'b01); nxt();
        set_a(2'b00, 0, 0, 2'b00);
        @(negedge clk); chk("fullrd_end_lvl", a_lvl, 0); nxt();

        // Flush with L = 3 and an active 11/11 handshake
        set_a(2'b11, 32'h60, 32'h61, 2'b00); nxt();
        set_a(2'b01, 32'h62, 0, 2'b00); nxt();
        a_flush = 1; set_a(2'b11, 32'h70, 32'h71, 2'b11); qa.delete();
        @(negedge clk); chk("flush_lvl_before", a_lvl, 3); chk("flush_wrdy", a_wrdy, 2'b11); nxt();
        a_flush = 0; set_a(2'b11, 32'h80, 32'h81, 2'b00); qa.push_back(32'h80); qa.push_back(32'h81);
        @(negedge clk);
        chk("flush_lvl", a_lvl, 0); chk("flush_rdv", a_rdv, 2'b00); chk("flush_empty", a_empty, 1);
        nxt();
        set_a(2'b00, 0, 0, 2'b11);
        nxt();

        // Reset mid-stream
        set_a(2'b11, 32'h90, 32'h91, 2'b00); nxt();
        a_rst = 1; set_a(2'b11, 32'h92, 32'h93, 2'b11); qa.delete(); nxt();
        a_rst = 0; set_a(2'b00, 0, 0, 2'b00);
        @(negedge clk);
        chk("mrst_rdv", a_rdv, 2'b00); chk("mrst_wrdy", a_wrdy, 2'b11);
        chk("mrst_lvl", a_lvl, 0); chk("mrst_empty", a_empty, 1); chk("mrst_full", a_full, 0);
        chk("mrst_q0", a_q0, 0); chk("mrst_q1", a_q1, 0);
        nxt();

        // Fall-through on B
        set_b(2'b11, 32'hCAFE0, 32'hCAFE1, 2'b11); qb.push_back(32'hCAFE0); qb.push_back(32'hCAFE1);
        @(negedge clk); chk("ft_rdv2", b_rdv, 2'b11); nxt();
        set_b(2'b01, 32'hB0, 0, 2'b00); qb.push_back(32'hB0);
        @(negedge clk); chk("ft_lvl_stays0", b_lvl, 0); nxt();
        set_b(2'b01, 32'hB1, 0, 2'b11); qb.push_back(32'hB1);
        @(negedge clk); chk("ft_lvl1", b_lvl, 1); chk("ft_rdv_l1", b_rdv, 2'b11); nxt();
        set_b(2'b01, 32'hB2, 0, 2'b11); qb.push_back(32'hB2);
        @(negedge clk); chk("ft_lvl0", b_lvl, 0); chk("ft_rdv_single", b_rdv, 2'b01); nxt();
        set_b(2'b00, 0, 0, 2'b00);
        @(negedge clk); chk("ft_end_lvl", b_lvl, 0); chk("ft_end_empty", b_empty, 1); nxt();

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_fifo_deep.md
# stage_fifo_deep

Parametrised successor to the 2-entry dual-issue stage FIFO: a Depth-entry, Width-bit FIFO with the same 0/1/2-per-cycle valid/ready protocol on both ports. It adds an occupancy level output, full/empty flags and an optional fall-through mode in which written data is readable in the same cycle when the FIFO holds fewer than two entries. It sits between pipeline stages, for example fetch to decode, where more than two entries of decoupling are needed.

## Interface
- Width, 32: data bits per entry.
- Depth, 4: number of entries; legal range is >= 2; need not be a power of two.
- FallThrough, 1'b0: 1 enables the same-cycle write-to-read bypass.
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  synchronous empty; has priority over all transfers.
- wr_valid_i  in  2  write request: 00 = none, 01 = one item, 11 = two items; 10 is illegal.
- wr_data0_i  in  Width  first (older) write item.
- wr_data1_i  in  Width  second write item.
- wr_rdy_o  out  2  write room: 00, 01 or 11 only.
- rd_rdy_i  in  2  read request: 00, 01 or 11; 10 is illegal.
- rd_valid_o  out  2  read availability: 00, 01 or 11 only.
- rd_data0_o  out  Width  oldest item.
- rd_data1_o  out  Width  second-oldest item.
- level_o  out  $clog2(Depth+1)  registered occupancy L.
- empty_o  out  1  L == 0.
- full_o  out  1  L == Depth.

## Operation
- State:
  - rd_ptr and wr_ptr, range 0..Depth-1. Increment is modulo Depth, implemented by an explicit compare-and-wrap, not bit truncation.
  - L, range 0..Depth.
  - mem[Depth].
- Request counts:
  - rq = 0 / 1 / 2 for rd_rdy_i = 00 / 01 / 11.
  - wq = 0 / 1 / 2 for wr_valid_i = 00 / 01 / 11.
  - The illegal code 10 counts as 0 (no transfer).
- Stored reads: ns = min(rq, L).
- Room and write acceptance:
  - room = Depth − L + ns.
  - wr_rdy_o = 11 if room ≥ 2, 01 if room == 1, 00 otherwise.
  - Accepted writes: nw = min(wq, room).
  - A writer asserting 11 against wr_rdy_o = 01 has only wr_data0_i accepted.
- Read availability:
  - avail = min(2, L) when FallThrough = 0.
  - avail = min(2, L + nw) when FallThrough = 1.
  - rd_valid_o encodes avail as 00 / 01 / 11.
  - Accepted reads: nr = min(rq, avail). rd_rdy_i = 11 against rd_valid_o = 01 reads one item.
- Read data, FallThrough = 0:
  - rd_data0_o = mem[rd_ptr].
  - rd_data1_o = mem[rd_ptr+1 mod Depth].
- Read data, FallThrough = 1:
  - When L ≥ 2: same as FallThrough = 0.
  - When L == 1: rd_data0_o = mem[rd_ptr], rd_data1_o = wr_data0_i.
  - When L == 0: rd_data0_o = wr_data0_i, rd_data1_o = wr_data1_i.
- Commit, when neither flush_i nor rst_i is asserted:
  - Accepted items are written to mem[wr_ptr] and, for the second item, mem[wr_ptr+1 mod Depth], including bypassed items.
  - wr_ptr += nw; rd_ptr += nr; L ← L + nw − nr.
- Flush: pointers and L go to 0 on the next cycle. No write or read commits in the flush cycle, even if handshakes appear complete on the ports. Memory contents are kept.
- Reset: pointers, L and every mem entry are cleared to 0.
- Combinational paths:
  - wr_rdy_o depends on rd_rdy_i. With FallThrough = 1, rd_valid_o and rd_data*_o also depend on wr_valid_i and wr_data*_i.
  - There are no loops, because room uses ns (stored items only), never the bypassed items.

## Timing
- Output values during and after reset:
  - rd_valid_o = 00, wr_rdy_o = 11.
  - level_o = 0, empty_o = 1, full_o = 0.
  - rd_data0_o = rd_data1_o = 0 when FallThrough = 0; with FallThrough = 1 they follow wr_data0_i / wr_data1_i while empty.
- Write-to-read latency: 1 cycle with FallThrough = 0, 0 cycles with FallThrough = 1.
- level_o, empty_o and full_o are registered and reflect the state after the previous edge.
- Full with rd_rdy_i = 11: wr_rdy_o = 11, so two writes and two reads occur in the same cycle and L is unchanged.
- Full with rd_rdy_i = 01: wr_rdy_o = 01.
- Empty with FallThrough = 0: rd_valid_o = 00 even if writes are present.
- Pointer wrap: Depth−1 → 0. A dual write or dual read that straddles the wrap uses entries Depth−1 and 0.
- Reset or flush asserted mid-burst: the state is empty on the following cycle and partial transfers are discarded.

## Test plan
- Fill/drain, Depth = 3, FallThrough = 0:
  - Stimulus: write 11 (A, B) then write 01 (C) with no reads.
  - Response: level_o = 3, full_o = 1, wr_rdy_o = 00 when rd_rdy_i = 00. Reading 11 then 01 returns A/B, then C. level_o = 0.
- Wrap, Depth = 3:
  - Stimulus: continuous write 11 and read 11 over 10 cycles, with 0..19 in order.
  - Response: in-order data, no loss, level_o constant.
- Partial acceptance:
  - Stimulus: L = Depth−1, wr_valid_i = 11, rd_rdy_i = 00.
  - Response: wr_rdy_o = 01, only wr_data0_i stored, full_o = 1 on the next cycle.
- Full with simultaneous read:
  - Stimulus: L = Depth, rd_rdy_i = 01, wr_valid_i = 11.
  - Response: wr_rdy_o = 01, one read and one write, L = Depth.
- Fall-through, Depth = 4:
  - Stimulus 1: empty, write 11 (X, Y), rd_rdy_i = 11.
  - Response 1: same cycle rd_valid_o = 11, rd_data0_o = X, rd_data1_o = Y, level_o stays 0.
  - Stimulus 2: L = 1 holding P, write 01 (Q), read 11.
  - Response 2: reads P and Q.
- Flush/reset:
  - Stimulus: flush_i with L = 3 and an active 11/11 handshake.
  - Response: next cycle level_o = 0, rd_valid_o = 00, and data written after the flush is read first.
  - Stimulus: rst_i mid-stream.
  - Response: all outputs take their reset values next cycle.
